control_logic: RTL and testbench
================================

Name: control_logic

Overview:
- Sequential core of an 8x8 Conway's Game of Life engine.
- Loads a 64-bit seed pattern after reset. While enabled, computes one new generation per clock.
- Presents the current board on a 64-bit bus for display and output logic.
- Sits between the seed source (switches/constant) and the display driver.

Parameters:
- None. Board size is fixed at 8x8 = 64 cells.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- seed  input  64  initial board pattern, sampled in the LOAD state.
- switch  input  1  run enable: 1 = advance one generation per clock, 0 = hold the board.
- current_iteration  output  64  current board, driven directly from the board register.

Behaviour:
- Board mapping:
  - Cell (row r, col c), r,c in 0..7, is bit 8*r+c.
  - Row r occupies bits [8r+7:8r]. Bit 1 = live, 0 = dead.
- State register, two states: LOAD and RUN.
- reset asserted (asynchronous, at any time, including mid-run):
  - state = LOAD.
  - board = 64'h0, so current_iteration = 0 immediately.
- LOAD, first rising clk edge with reset low:
  - board <= seed; state -> RUN.
  - switch is ignored in LOAD.
  - Seed appears on current_iteration one cycle after reset release.
- RUN, each rising clk edge:
  - switch==1: board <= next(board).
  - switch==0: board holds.
  - switch X/Z is treated as "not 1", so the board holds.
- RUN persists until the next reset. seed changes after the load have no effect.
- next(board), computed combinationally for all 64 cells in parallel:
  - n = count of live cells among the 8 neighbours (3-bit+ count, range 0..8, no overflow).
  - Live cell survives iff n==2 or n==3; otherwise it dies.
  - Dead cell becomes live iff n==3.
- Edge handling (default): cells outside rows/cols 0..7 count as dead; there is no wrap.
- Latency: one clock per generation. current_iteration reflects the register output with no combinational path from seed or switch.
- All-zero board stays all-zero. Still lifes (e.g. block) are stable when running.

Optional Feature:
- Macro LIFE_TORUS_WRAP_EN.
- Defined: board is a torus.
  - Neighbour row/col indices wrap modulo 8, so row 7 is adjacent to row 0 and col 7 is adjacent to col 0.
  - Corner cells get neighbours from the three opposite edges/corners.
- Undefined: dead-boundary behaviour as specified above.
- Interior cells (rows/cols 1..6) behave identically in both builds.

Test Plan:
- Reset and load:
  - Stimulus: reset=1 with seed=64'h0412_6424_0034_3C28.
  - Required: current_iteration==0 asynchronously.
  - Release reset, one clk: current_iteration==64'h0412_6424_0034_3C28, regardless of switch.
- Blinker:
  - Stimulus: seed=64'h0000_0000_1C00_0000, switch=1.
  - Required: board alternates between 64'h0000_0008_0808_0000 and 64'h0000_0000_1C00_0000 on successive clocks.
- Still life:
  - Stimulus: seed=64'h0000_0000_0000_0303, switch=1 for 10 clocks.
  - Required: board remains 64'h0303. Seed 0 remains 0.
- Hold:
  - Stimulus: blinker running, switch=0 for 5 clocks.
  - Required: board frozen at its last value. With switch=1 again it resumes alternating.
- Edge (default build):
  - Stimulus: seed=64'h0000_0000_0101_0100 (col 0, rows 1..3), one step.
  - Required: board = 64'h0000_0000_0003_0000 (cells (2,0) and (2,1)).
  - With LIFE_TORUS_WRAP_EN: board = 64'h0000_0000_0083_0000.
- Reset mid-run:
  - Stimulus: assert reset between clock edges during RUN.
  - Required: current_iteration goes to 0 without a clock edge. After release, the seed reloads one clock later.

Source files
------------

// File: rtl/control_logic.sv
// Sequential core of an 8x8 Game of Life engine: loads a seed, then steps one generation per clock.
// Define LIFE_TORUS_WRAP_EN to make the board a torus; otherwise cells beyond the edges are dead.
module control_logic (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] seed,
   input  logic        switch,
   output logic [63:0] current_iteration
);

   typedef enum logic {LOAD, RUN} state_t;

   state_t      state, state_next;
   logic [63:0] board, board_d, next_board;

   // Returns the live bit of cell (r, c); out-of-range coordinates follow the edge policy.
   function automatic logic cell_at(input logic [63:0] b, input int r, input int c);
      int rr, cc;
`ifdef LIFE_TORUS_WRAP_EN
      rr = r & 7;
      cc = c & 7;
      return b[6'(8 * rr + cc)];
`else
      rr = r;
      cc = c;
      if (rr < 0 || rr > 7 || cc < 0 || cc > 7) return 1'b0;
      return b[6'(8 * rr + cc)];
`endif
   endfunction

   always_comb begin
      logic [3:0] n;
      logic       alive;
      next_board = '0;
      n          = '0;
      alive      = 1'b0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            n = '0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (!(dr == 0 && dc == 0)) n = n + {3'b000, cell_at(board, r + dr, c + dc)};
               end
            end
            alive = board[6'(8 * r + c)];
            next_board[6'(8 * r + c)] = (n == 4'd3) || (alive && n == 4'd2);
         end
      end
   end

   always_comb begin
      state_next = state;
      board_d    = board;
      case (state)
         LOAD: begin
            board_d    = seed;
            state_next = RUN;
         end
         RUN: begin
            // Anything other than a clean 1 on switch holds the board.
            if (switch == 1'b1) board_d = next_board;
         end
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LOAD;
         board <= '0;
      end else begin
         state <= state_next;
         board <= board_d;
      end
   end

   assign current_iteration = board;

endmodule

// File: tb/tb_control_logic.sv
// Self-checking bench for control_logic: directed Life patterns plus random boards against a grid model.
module tb_control_logic;

   logic        clk;
   logic        reset;
   logic [63:0] seed;
   logic        switch;
   logic [63:0] current_iteration;

   int tests = 0;
   int fails = 0;
   logic [63:0] exp_b;

   control_logic dut (
      .clk(clk),
      .reset(reset),
      .seed(seed),
      .switch(switch),
      .current_iteration(current_iteration)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference generation step on an 8x8 integer grid.
   function automatic logic [63:0] life_step(input logic [63:0] b);
      int g[8][8];
      logic [63:0] t;
      logic [63:0] res;
      int n, nr, nc;
      res = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            t = b >> (8 * r + c);
            g[r][c] = t[0] ? 1 : 0;
         end
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr == 0 && dc == 0) continue;
`ifdef LIFE_TORUS_WRAP_EN
                  nr = (r + dr + 8) % 8;
                  nc = (c + dc + 8) % 8;
`else
                  nr = r + dr;
                  nc = c + dc;
                  if (nr < 0 || nr > 7 || nc < 0 || nc > 7) continue;
`endif
                  n += g[nr][nc];
               end
            if (n == 3 || (g[r][c] == 1 && n == 2)) res = res | (64'd1 << (8 * r + c));
         end
      return res;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Step one clock and advance the model under the current switch value.
   task automatic run_step(input string tag);
      tick();
      if (switch === 1'b1) exp_b = life_step(exp_b);
      check(tag, current_iteration, exp_b);
   endtask

   // Asynchronous reset between edges, then load the given seed.
   task automatic do_load(input logic [63:0] s, input logic sw);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", current_iteration, 64'h0);
      tick();
      seed   = s;
      switch = sw;
      reset  = 1'b0;
      tick();
      exp_b = s;
      check("load", current_iteration, s);
   endtask

   initial begin
      reset  = 1'b1;
      seed   = 64'h0412_6424_0034_3C28;
      switch = 1'b0;
      tick();
      check("reset_state", current_iteration, 64'h0);
      reset  = 1'b0;
      switch = 1'b1;
      tick();
      exp_b = 64'h0412_6424_0034_3C28;
      check("first_load", current_iteration, exp_b);

      // Blinker alternation, then hold, then resume.
      do_load(64'h0000_0000_1C00_0000, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("blinker", current_iteration,
               (i % 2 == 0) ? 64'h0000_0008_0808_0000 : 64'h0000_0000_1C00_0000);
      end
      tick();
      check("blinker_pre_hold", current_iteration, 64'h0000_0008_0808_0000);
      switch = 1'b0;
      seed   = 64'hFFFF_0000_FFFF_0000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold", current_iteration, 64'h0000_0008_0808_0000);
      end
      switch = 1'bx;
      tick();
      check("hold_x", current_iteration, 64'h0000_0008_0808_0000);
      switch = 1'b1;
      tick();
      check("resume_a", current_iteration, 64'h0000_0000_1C00_0000);
      tick();
      check("resume_b", current_iteration, 64'h0000_0008_0808_0000);

      // Still life and empty board.
      do_load(64'h0000_0000_0000_0303, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("block", current_iteration, 64'h0000_0000_0000_0303);
      end
      do_load(64'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("empty", current_iteration, 64'h0);
      end

      // Edge column: result depends on the boundary policy.
      do_load(64'h0000_0000_0101_0100, 1'b1);
      tick();
`ifdef LIFE_TORUS_WRAP_EN
      check("edge", current_iteration, 64'h0000_0000_0083_0000);
`else
      check("edge", current_iteration, 64'h0000_0000_0003_0000);
`endif

      // Load ignores switch=0.
      do_load(64'h0000_0000_1C00_0000, 1'b0);
      switch = 1'b1;
      run_step("load_sw0_run");

      // Random boards with random run/hold pattern.
      for (int k = 0; k < 20; k++) begin
         do_load({$urandom, $urandom}, 1'($urandom_range(0, 1)));
         for (int i = 0; i < 8; i++) begin
            switch = 1'($urandom_range(0, 3) != 0);
            seed   = {$urandom, $urandom};
            run_step("random_gen");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL timeout tests=%0d", tests);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
